arbiter_mem_slave: RTL and testbench

Word-addressed synchronous memory slave directly downstream of the 4-host round-robin arbiter. It consumes the arbiter's shared slave bus: address, byte enables, read/write strobes, write data and CPU ID. It services one transfer at a time with a programmable number of wait states and returns read data plus a single-cycle `ack_bus` pulse. The arbiter routes that pulse back to the granted host.

---
 rtl/arbiter_mem_slave.sv | 126 ++++++++++++
 tb/tb_arbiter_mem_slave.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/arbiter_mem_slave.sv
// rtl/arbiter_mem_slave.sv - word-addressed memory slave behind the 4-host arbiter
// Optional write protection of the top address quarter: MEM_SLAVE_WPROT_EN
module arbiter_mem_slave #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int CPU_W       = 2,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   add_bus,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                wr_bus,
    input  logic                rd_bus,
    input  logic [DATA_W-1:0]   data_bus_wr,
    input  logic [CPU_W-1:0]    cpu_bus,
    output logic [DATA_W-1:0]   data_bus_rd,
    output logic                ack_bus,
    output logic                busy,
`ifdef MEM_SLAVE_WPROT_EN
    output logic                err_wprot,
`endif
    output logic                err_proto
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rd, r_wr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err_proto;
    logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

    logic                w_req, w_accept;
    logic                w_cur_rd, w_cur_wr;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic                w_load_rd, w_do_write;

    assign w_req    = rd_bus | wr_bus;
    assign w_accept = (r_state == S_IDLE) && w_req;

    // With zero wait states IDLE goes straight to ACK, so the live bus stands in for the latches
    assign w_cur_rd   = (r_state == S_IDLE) ? rd_bus  : r_rd;
    assign w_cur_wr   = (r_state == S_IDLE) ? wr_bus  : r_wr;
    assign w_cur_addr = (r_state == S_IDLE) ? add_bus : r_addr;
    assign w_load_rd  = (w_next == S_ACK) && (r_state != S_ACK) && w_cur_rd;

`ifdef MEM_SLAVE_WPROT_EN
    logic [CPU_W-1:0] r_cpu;
    logic             w_wprot_hit;
    assign w_wprot_hit = r_wr && !r_rd && (r_addr[ADDR_W-1:ADDR_W-2] == 2'b11) && (r_cpu != '0);
    assign err_wprot   = (r_state == S_ACK) && w_wprot_hit;
    assign w_do_write  = (r_state == S_ACK) && r_wr && !r_rd && !w_wprot_hit;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu <= '0;
        end else if (w_accept) begin
            r_cpu <= cpu_bus;
        end
    end
`else
    logic w_unused_cpu;
    assign w_unused_cpu = ^cpu_bus;
    assign w_do_write   = (r_state == S_ACK) && r_wr && !r_rd;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
            S_WAIT: if (r_cnt == 4'd0) w_next = S_ACK;
            S_ACK:  w_next = S_HOLD;
            S_HOLD: if (!rd_bus && !wr_bus) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_rdata     <= '0;
            r_err_proto <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= add_bus;
                r_be    <= byte_en;
                r_wdata <= data_bus_wr;
                r_rd    <= rd_bus;
                r_wr    <= wr_bus;
                r_cnt   <= CNT_INIT;
                if (rd_bus && wr_bus) r_err_proto <= 1'b1;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Read data is fetched on the way into ACK so it is valid alongside the ack pulse
            if (w_load_rd) r_rdata <= w_cur_wr ? '0 : r_mem[w_cur_addr];
        end
    end

    // Memory is not reset; a write sitting in ACK at a reset edge is dropped
    always_ff @(posedge clk) begin
        if (!reset && w_do_write) begin
            for (int i = 0; i < BE_W; i++) begin
                if (r_be[i]) r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign ack_bus     = (r_state == S_ACK);
    assign busy        = (r_state != S_IDLE);
    assign data_bus_rd = r_rdata;
    assign err_proto   = r_err_proto;
endmodule

// File: tb/tb_arbiter_mem_slave.sv
// tb/tb_arbiter_mem_slave.sv - scoreboard bench for arbiter_mem_slave
module tb_arbiter_mem_slave;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  add_bus;
    logic [3:0]  byte_en;
    logic        wr_bus, rd_bus;
    logic [31:0] data_bus_wr;
    logic [1:0]  cpu_bus;
    logic [31:0] data_bus_rd;
    logic        ack_bus, busy, err_proto;
`ifdef MEM_SLAVE_WPROT_EN
    logic        err_wprot;
`endif

    arbiter_mem_slave #(.ADDR_W(10), .DATA_W(32), .CPU_W(2), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .add_bus(add_bus), .byte_en(byte_en),
        .wr_bus(wr_bus), .rd_bus(rd_bus), .data_bus_wr(data_bus_wr), .cpu_bus(cpu_bus),
        .data_bus_rd(data_bus_rd), .ack_bus(ack_bus), .busy(busy),
`ifdef MEM_SLAVE_WPROT_EN
        .err_wprot(err_wprot),
`endif
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    logic [31:0] model [0:1023];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [9:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic [1:0] cpu, input int hold, input string tag);
        int lat;
        int extra;
        bit prot;
        logic wp_seen;
        logic [31:0] m;
        prot = 1'b0;
`ifdef MEM_SLAVE_WPROT_EN
        prot = wr && !rd && (a[9:8] == 2'b11) && (cpu != 2'd0);
`endif
        rd_bus = rd; wr_bus = wr; add_bus = a; byte_en = be; data_bus_wr = d; cpu_bus = cpu;
        if (rd) exp_q.push_back(wr ? 32'h0 : model[a]);
        else if (wr && !prot) begin
            m = model[a];
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
            model[a] = m;
        end
        @(posedge clk);
        lat = 0;
        wp_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                add_bus = ~a; data_bus_wr = ~d; byte_en = 4'hF; cpu_bus = 2'd0;
            end
        end while (!ack_bus && lat < 20);
`ifdef MEM_SLAVE_WPROT_EN
        wp_seen = err_wprot;
        check({tag, ".wprot"}, {31'b0, wp_seen}, {31'b0, prot});
`endif
        check({tag, ".lat"}, lat, WS + 1);
        extra = 0;
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            if (ack_bus) extra++;
        end
        if (rd) begin
            if (exp_q.size() == 0) check({tag, ".q_empty"}, 32'd1, 32'd0);
            else begin
                last_rd = exp_q.pop_front();
                check({tag, ".rdata"}, data_bus_rd, last_rd);
            end
        end else begin
            check({tag, ".rd_hold"}, data_bus_rd, last_rd);
        end
        check({tag, ".extra_ack"}, extra, 0);
        rd_bus = 1'b0; wr_bus = 1'b0;
        @(negedge clk);
        check({tag, ".idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        last_rd = 32'h0;
        reset = 1'b1; rd_bus = 0; wr_bus = 0; add_bus = 0; byte_en = 0; data_bus_wr = 0; cpu_bus = 0;
        repeat (3) @(negedge clk);
        check("rst.ack", {31'b0, ack_bus}, 0);
        check("rst.busy", {31'b0, busy}, 0);
        check("rst.err_proto", {31'b0, err_proto}, 0);
        check("rst.rdata", data_bus_rd, 0);
        reset = 1'b0;
        @(negedge clk);

        xfer(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 2'd1, 0, "w_full");
        xfer(1, 0, 10'h005, 4'hF, 32'h0, 2'd1, 0, "r_full");
        xfer(0, 1, 10'h005, 4'b0101, 32'h11223344, 2'd2, 0, "w_part");
        xfer(1, 0, 10'h005, 4'h0, 32'h0, 2'd2, 0, "r_part");
        check("r_part.const", last_rd, 32'hDE22BE44);
        xfer(1, 0, 10'h005, 4'hF, 32'h0, 2'd3, 6, "r_hold6");

        xfer(0, 1, 10'h010, 4'hF, 32'hCAFEF00D, 2'd1, 0, "w_010");
        xfer(1, 1, 10'h010, 4'hF, 32'h55555555, 2'd1, 0, "proto");
        check("proto.err", {31'b0, err_proto}, 1);
        xfer(1, 0, 10'h010, 4'hF, 32'h0, 2'd1, 0, "r_010");
        check("proto.sticky", {31'b0, err_proto}, 1);

        xfer(0, 1, 10'h005, 4'h0, 32'hFFFFFFFF, 2'd0, 0, "w_be0");
        xfer(1, 0, 10'h005, 4'hF, 32'h0, 2'd0, 0, "r_be0");

        xfer(0, 1, 10'h3FF, 4'hF, 32'h0BADC0DE, 2'd0, 0, "w_top");
        xfer(1, 0, 10'h3FF, 4'hF, 32'h0, 2'd0, 0, "r_top");

        xfer(0, 1, 10'h020, 4'hF, 32'hA5A5A5A5, 2'd1, 0, "w_020");
        wr_bus = 1'b1; add_bus = 10'h020; byte_en = 4'hF; data_bus_wr = 32'h12121212; cpu_bus = 2'd1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; wr_bus = 1'b0;
        @(negedge clk);
        check("rst_mid.busy", {31'b0, busy}, 0);
        check("rst_mid.ack", {31'b0, ack_bus}, 0);
        check("rst_mid.err_proto", {31'b0, err_proto}, 0);
        reset = 1'b0;
        last_rd = 32'h0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_bus) cnt++;
        end
        check("rst_mid.no_ack", cnt, 0);
        xfer(1, 0, 10'h020, 4'hF, 32'h0, 2'd1, 0, "r_020");

`ifdef MEM_SLAVE_WPROT_EN
        xfer(0, 1, 10'h300, 4'hF, 32'h0BADF00D, 2'd0, 0, "wp_init");
        xfer(0, 1, 10'h300, 4'hF, 32'h12345678, 2'd2, 0, "wp_cpu2");
        xfer(1, 0, 10'h300, 4'hF, 32'h0, 2'd2, 0, "wp_rd1");
        check("wp_rd1.const", last_rd, 32'h0BADF00D);
        xfer(0, 1, 10'h300, 4'hF, 32'h12345678, 2'd0, 0, "wp_cpu0");
        xfer(1, 0, 10'h300, 4'hF, 32'h0, 2'd0, 0, "wp_rd2");
        check("wp_rd2.const", last_rd, 32'h12345678);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
